// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU datapath: operand width, lookahead group
// size, add/sub op encoding, the flag bundle used by downstream flag logic,
// and the 4-bit carry-lookahead equations used at both lookahead levels.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_GRP   = 4;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  typedef struct packed {
    logic c_out;
    logic ovf;
    logic zero;
  } alu_flags_t;

  // Carries c1..c3 inside a 4-wide group, from the group carry-in.
  function automatic logic [2:0] cla_inner(input logic [2:0] p,
                                           input logic [2:0] g,
                                           input logic       cin);
    logic [2:0] c;
    c[0] = g[0] | (p[0] & cin);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
           (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  // Group propagate: all four positions propagate.
  function automatic logic cla_group_p(input logic [3:0] p);
    return &p;
  endfunction

  // Group generate: a carry is born somewhere and propagated to the top.
  function automatic logic cla_group_g(input logic [3:0] p,
                                       input logic [3:0] g);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
           (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Carries c1..c4 of a 4-wide group; c4 is G | P & cin.
  function automatic logic [3:0] cla_carries(input logic [3:0] p,
                                             input logic [3:0] g,
                                             input logic       cin);
    return {cla_group_g(p, g) | (cla_group_p(p) & cin),
            cla_inner(p[2:0], g[2:0], cin)};
  endfunction

endpackage

// File: rtl/alu_pg_gen.sv
// ---------------------------------------------------------------------------
// alu_pg_gen
// Combinational operand transform and per-bit propagate/generate formation.
// For subtraction B is inverted here; the +1 enters as the carry-in.
// Ports:
//   a, b  in  WIDTH  operands
//   sub   in  1      0 = add, 1 = subtract
//   p     out WIDTH  a ^ b_eff
//   g     out WIDTH  a & b_eff
// ---------------------------------------------------------------------------
module alu_pg_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] g
);

  logic [WIDTH-1:0] b_eff;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign b_eff[gi] = (sub == ALU_OP_SUB) ? ~b[gi] : b[gi];
      assign p[gi]     = a[gi] ^ b_eff[gi];
      assign g[gi]     = a[gi] & b_eff[gi];
    end
  endgenerate

endmodule

// File: rtl/add_pipe32.sv
// ---------------------------------------------------------------------------
// add_pipe32
// Two-stage pipelined add/subtract unit with valid/ready on both sides.
// Stage 1 registers per-bit propagate/generate and the carry-in. Stage 2
// resolves carries with two-level 4-bit group lookahead and registers the
// sum and flags, which drive the outputs directly.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand beat handshake
//   a, b, sub             operands and op (0 = A+B, 1 = A-B)
//   out_valid / out_ready result beat handshake
//   sum, c_out, ovf, zero result and flags (c_out = 1 means no borrow on sub)
// WIDTH must be a multiple of 16 so groups-of-groups tile exactly.
// ---------------------------------------------------------------------------
module add_pipe32
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / ALU_GRP;  // first-level groups
  localparam int NS = NG / ALU_GRP;     // second-level groups of groups

  // ---------------- handshake ----------------
  logic v1_reg, v2_reg;
  logic adv1, adv2;

  assign adv2     = ~v2_reg | out_ready;
  assign adv1     = ~v1_reg | adv2;
  assign in_ready = adv1;

  // ---------------- stage 1 ----------------
  logic [WIDTH-1:0] p_in, g_in;
  logic [WIDTH-1:0] p_reg, g_reg;
  logic             c0_reg;

  alu_pg_gen #(.WIDTH(WIDTH)) u_pg (
    .a   (a),
    .b   (b),
    .sub (sub),
    .p   (p_in),
    .g   (g_in)
  );

  // Operand registers load only on an accepted beat so idle/X inputs
  // never reach the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg <= 1'b0;
      p_reg  <= '0;
      g_reg  <= '0;
      c0_reg <= 1'b0;
    end else if (adv1) begin
      v1_reg <= in_valid;
      if (in_valid) begin
        p_reg  <= p_in;
        g_reg  <= g_in;
        c0_reg <= sub;
      end
    end
  end

  // ---------------- stage 2 lookahead ----------------
  logic [NG-1:0] grp_p, grp_g;
  logic [NG:0]   grp_c;    // carry into each first-level group
  logic [WIDTH:0] c;       // carry into each bit, c[WIDTH] = carry out

  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      assign grp_p[gi] = cla_group_p(p_reg[gi*ALU_GRP +: ALU_GRP]);
      assign grp_g[gi] = cla_group_g(p_reg[gi*ALU_GRP +: ALU_GRP],
                                     g_reg[gi*ALU_GRP +: ALU_GRP]);
    end
  endgenerate

  // Second level: each group of four groups resolves its group carries
  // from its own carry-in; only the group-of-groups carry chains onward.
  always_comb begin
    grp_c    = '0;
    grp_c[0] = c0_reg;
    for (int k = 0; k < NS; k++) begin
      grp_c[k*ALU_GRP+1 +: ALU_GRP] =
        cla_carries(grp_p[k*ALU_GRP +: ALU_GRP],
                    grp_g[k*ALU_GRP +: ALU_GRP],
                    grp_c[k*ALU_GRP]);
    end
  end

  // First level: bit carries inside each group from its group carry-in.
  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_bitc
      assign c[gi*ALU_GRP]             = grp_c[gi];
      assign c[gi*ALU_GRP+1 +: ALU_GRP-1] =
        cla_inner(p_reg[gi*ALU_GRP +: ALU_GRP-1],
                  g_reg[gi*ALU_GRP +: ALU_GRP-1],
                  grp_c[gi]);
    end
  endgenerate

  assign c[WIDTH] = grp_c[NG];

  logic [WIDTH-1:0] sum_next;
  alu_flags_t       flags_next;

  assign sum_next         = p_reg ^ c[WIDTH-1:0];
  assign flags_next.c_out = c[WIDTH];
  assign flags_next.ovf   = c[WIDTH] ^ c[WIDTH-1];
  assign flags_next.zero  = ~|sum_next;

  // ---------------- stage 2 registers ----------------
  logic [WIDTH-1:0] sum_reg;
  alu_flags_t       flags_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_reg    <= 1'b0;
      sum_reg   <= '0;
      flags_reg <= '0;
    end else if (adv2) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        sum_reg   <= sum_next;
        flags_reg <= flags_next;
      end
    end
  end

  assign out_valid = v2_reg;
  assign sum       = sum_reg;
  assign c_out     = flags_reg.c_out;
  assign ovf       = flags_reg.ovf;
  assign zero      = flags_reg.zero;

endmodule

// File: tb/tb_add_pipe32.sv
// ---------------------------------------------------------------------------
// tb_add_pipe32
// Scoreboard bench for add_pipe32: expected results are queued when a beat
// is accepted and compared in order when a result beat transfers.
// ---------------------------------------------------------------------------
module tb_add_pipe32;
  import alu_pkg::*;

  localparam int W = ALU_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;
  logic         zero;

  add_pipe32 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         zero;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  int           pops   = 0;
  bit           lat_chk = 1'b0;
  bit           fixed_valid = 1'b0;
  exp_t         fixed_exp;
  bit           held = 1'b0;
  logic [W-1:0] held_sum;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide addition; overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s);
    exp_t         e;
    logic [W:0]   full;
    logic [W-1:0] ye;
    ye      = s ? ~y : y;
    full    = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, s};
    e.sum   = full[W-1:0];
    e.c_out = full[W];
    e.ovf   = (x[W-1] == ye[W-1]) && (full[W-1] != x[W-1]);
    e.zero  = (full[W-1:0] == '0);
    e.cyc   = 0;
    e.lat   = 1'b0;
    return e;
  endfunction

  // One clock: sample at the falling edge, score both handshakes, then
  // return just after the rising edge so the caller can drive new inputs.
  task automatic tick(output bit acc);
    exp_t e;
    @(negedge clk);
    check("in_ready", {63'd0, in_ready},
          (sb.size() == 2 && !out_ready) ? 64'd0 : 64'd1);
    if (held && out_valid) check("held_sum", {32'd0, sum}, {32'd0, held_sum});
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", {63'd0, out_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        pops++;
        $display("OUT #%0d sum=%h c_out=%0d ovf=%0d zero=%0d (exp %h %0d %0d %0d)",
                 pops, sum, c_out, ovf, zero, e.sum, e.c_out, e.ovf, e.zero);
        check("sum",   {32'd0, sum},   {32'd0, e.sum});
        check("c_out", {63'd0, c_out}, {63'd0, e.c_out});
        check("ovf",   {63'd0, ovf},   {63'd0, e.ovf});
        check("zero",  {63'd0, zero},  {63'd0, e.zero});
        if (e.lat) check("latency", 64'(cyc - e.cyc), 64'd2);
      end
    end
    acc = in_valid && in_ready;
    if (acc) begin
      e     = fixed_valid ? fixed_exp : model(a, b, sub);
      e.cyc = cyc;
      e.lat = lat_chk;
      sb.push_back(e);
    end
    held     = out_valid && !out_ready;
    held_sum = sum;
    @(posedge clk);
    #1;
  endtask

  task automatic send_fixed(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic s, input logic [W-1:0] es,
                            input logic ec, input logic eo, input logic ez);
    bit acc;
    fixed_exp.sum   = es;
    fixed_exp.c_out = ec;
    fixed_exp.ovf   = eo;
    fixed_exp.zero  = ez;
    fixed_valid     = 1'b1;
    a = x; b = y; sub = s; in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) tick(acc);
    check("send_accept", {63'd0, acc}, 64'd1);
    in_valid    = 1'b0;
    fixed_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick(acc);
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    bit           acc;
    int           idx;
    int           n;
    int           t;
    int           p0;
    logic [W-1:0] bp_a [6];
    logic [W-1:0] bp_b [6];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = ALU_OP_ADD;

    // Reset state
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum",       {32'd0, sum},       64'd0);
    check("rst_flags",     {61'd0, c_out, ovf, zero}, 64'd0);
    #11 rst_n = 1'b1;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Directed arithmetic corners, latency checked
    lat_chk = 1'b1;
    send_fixed(32'hFFFF_FFFF, 32'h0000_0001, ALU_OP_ADD, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    drain();
    send_fixed(32'h7FFF_FFFF, 32'h0000_0001, ALU_OP_ADD, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    drain();
    send_fixed(32'h0000_0005, 32'h0000_0007, ALU_OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    drain();
    send_fixed(32'h8000_0000, 32'h0000_0001, ALU_OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    drain();
    send_fixed(32'h1234_5678, 32'h1234_5678, ALU_OP_SUB, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    drain();
    lat_chk = 1'b0;

    // Back-pressure: 6 back-to-back beats, out_ready low for cycles 3..5
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = 32'h1000_0000 * (i + 1) + 32'h0000_0101 * i;
      bp_b[i] = 32'h0F0F_0F0F + i;
    end
    idx = 0;
    for (t = 0; t < 40 && (idx < 6 || sb.size() != 0); t++) begin
      out_ready = !(t >= 3 && t <= 5);
      in_valid  = (idx < 6);
      if (idx < 6) begin
        a = bp_a[idx]; b = bp_b[idx]; sub = idx[0];
      end
      if (t == 4) check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      tick(acc);
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_all_sent", 64'(idx), 64'd6);
    check("bp_all_recv", 64'(sb.size()), 64'd0);

    // Full-rate random stream
    p0 = pops;
    n  = 0;
    for (t = 0; t < 1100 && (n < 1000 || sb.size() != 0); t++) begin
      in_valid = (n < 1000);
      a   = $urandom;
      b   = $urandom;
      sub = 1'($urandom_range(0, 1));
      tick(acc);
      if (acc) n++;
    end
    in_valid = 1'b0;
    check("stream_count",  64'(pops - p0), 64'd1000);
    check("stream_cycles", 64'(t), 64'd1002);

    // Reset while both stages hold beats
    out_ready = 1'b0;
    a = 32'h0000_00F0; b = 32'h0000_000F; sub = ALU_OP_ADD; in_valid = 1'b1;
    tick(acc);
    a = 32'h0000_1000; b = 32'h0000_0234;
    tick(acc);
    in_valid = 1'b0;
    check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_sum",       {32'd0, sum},       64'd0);
    sb.delete();
    held = 1'b0;
    in_valid = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1;
    @(posedge clk); #1;
    check("rst_ignores_in", {63'd0, out_valid}, 64'd0);
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    lat_chk = 1'b1;
    send_fixed(32'h0000_0003, 32'h0000_0004, ALU_OP_ADD, 32'h0000_0007, 1'b0, 1'b0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
